// File: rtl/decompression_unit_if.sv
// rtl/decompression_unit_if.sv - stream and control bundle for the zero-run decoder
//   master: drives start/total_len, the compressed pair stream and out_ready
//   slave : drives in_ready, the dense element stream and busy/done/err
interface decompression_unit_if #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4,
  parameter int LEN_W  = 10
);
  logic              start;
  logic [LEN_W:0]    total_len;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [IDX_W-1:0]  in_index;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [LEN_W-1:0]  out_pos;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              err;

  modport master (
    output start, total_len, in_valid, in_data, in_index, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_pos, out_last, busy, done, err
  );

  modport slave (
    input  start, total_len, in_valid, in_data, in_index, in_last, out_ready,
    output in_ready, out_valid, out_data, out_pos, out_last, busy, done, err
  );
endinterface

// File: rtl/decompression_unit.sv
// rtl/decompression_unit.sv - zero-run decoder expanding (value, run) pairs into a dense channel
//   clk, rst : single clock, synchronous active-high reset
//   bus      : slave side of decompression_unit_if
//              start/total_len begin a channel, in_* carries compressed pairs,
//              out_* carries dense elements with their position, busy/done/err report status
module decompression_unit #(
  parameter int DATA_W = 16,
  parameter int IDX_W  = 4,
  parameter int LEN_W  = 10
) (
  input  logic               clk,
  input  logic               rst,
  decompression_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ZERO,
    S_VAL,
    S_PAD,
    S_DONE
  } state_t;

  localparam logic [LEN_W:0]   POS_ONE = {{LEN_W{1'b0}}, 1'b1};
  localparam logic [IDX_W-1:0] RUN_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [LEN_W:0]    pos_q, pos_d;
  logic [LEN_W:0]    len_q, len_d;
  logic [IDX_W-1:0]  run_q, run_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic              last_f_q, last_f_d;
  logic              err_q, err_d;

  logic              emit_state;
  logic              out_valid;
  logic              overflow;
  logic              advance;
  logic              in_fire;
  logic [LEN_W:0]    pos_inc;

  assign pos_inc    = pos_q + POS_ONE;
  assign emit_state = (state_q == S_ZERO) || (state_q == S_VAL) || (state_q == S_PAD);
  assign out_valid  = emit_state && (pos_q < len_q);
  // Elements past len are discarded at one per cycle so the pair stream is
  // still fully consumed and the channel still terminates.
  assign overflow   = ((state_q == S_ZERO) || (state_q == S_VAL)) && (pos_q >= len_q);
  assign advance    = (out_valid && bus.out_ready) || overflow;
  assign in_fire    = (state_q == S_FETCH) && bus.in_valid;

  always_comb begin
    state_d  = state_q;
    pos_d    = pos_q;
    len_d    = len_q;
    run_d    = run_q;
    val_d    = val_q;
    last_f_d = last_f_q;
    err_d    = err_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          len_d   = bus.total_len;
          pos_d   = '0;
          err_d   = 1'b0;
          state_d = (bus.total_len == '0) ? S_DONE : S_FETCH;
        end
      end

      S_FETCH: begin
        if (in_fire) begin
          val_d    = bus.in_data;
          run_d    = bus.in_index;
          last_f_d = bus.in_last;
          state_d  = (bus.in_index != '0) ? S_ZERO : S_VAL;
        end
      end

      S_ZERO: begin
        if (advance) begin
          if (overflow) err_d = 1'b1;
          else          pos_d = pos_inc;
          run_d = run_q - RUN_ONE;
          if (run_q == RUN_ONE) state_d = S_VAL;
        end
      end

      S_VAL: begin
        if (advance) begin
          if (overflow) err_d = 1'b1;
          else          pos_d = pos_inc;
          if (!last_f_q)           state_d = S_FETCH;
          else if (overflow)       state_d = S_DONE;
          else if (pos_inc == len_q) state_d = S_DONE;
          else                     state_d = S_PAD;
        end
      end

      S_PAD: begin
        if (advance) begin
          pos_d = pos_inc;
          if (pos_inc == len_q) state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pos_q    <= '0;
      len_q    <= '0;
      run_q    <= '0;
      val_q    <= '0;
      last_f_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      len_q    <= len_d;
      run_q    <= run_d;
      val_q    <= val_d;
      last_f_q <= last_f_d;
      err_q    <= err_d;
    end
  end

  // All outputs decode registered state only; nothing here looks at bus inputs.
  assign bus.in_ready  = (state_q == S_FETCH);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = (state_q == S_VAL) ? val_q : '0;
  assign bus.out_pos   = pos_q[LEN_W-1:0];
  assign bus.out_last  = out_valid && (pos_inc == len_q);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.done      = (state_q == S_DONE);
  assign bus.err       = err_q;

endmodule
